data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words in the array.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, access latency in clock cycles (0..15).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports req_valid input 1 (request present) and req_ready output 1 (responder idle, can accept).
REQ-006 SHALL have ports req_write input 1 (1 = store, 0 = load) and req_addr input 32 (byte address).
REQ-007 SHALL have ports req_wdata input 32 (store data, right-aligned), req_size input 2 (00 byte, 01 half, 10 word, 11 illegal) and req_unsigned input 1 (zero-extend loads).
REQ-008 SHALL have ports rsp_valid output 1, rsp_ready input 1, rsp_rdata output 32 and rsp_error output 1.

Function
REQ-009 SHALL implement the FSM states IDLE, BUSY and RESP; req_ready SHALL be 1 only in IDLE.
REQ-010 SHALL accept a request on the edge where req_valid && req_ready, latching write, addr, wdata, size and unsigned; an unaccepted req_valid has no effect.
REQ-011 On accept, SHALL load the wait counter with WAIT_CYCLES-1 and enter BUSY, or, if WAIT_CYCLES=0, perform the access on the accept edge and enter RESP.
REQ-012 In BUSY, SHALL decrement the counter each edge; on the edge where it reads 0, SHALL perform the access and enter RESP.
REQ-013 Net latency: rsp_valid SHALL rise exactly WAIT_CYCLES+1 rising edges after and including the accept edge.
REQ-014 In RESP, rsp_valid SHALL be 1, and rsp_rdata and rsp_error SHALL be held stable until the edge with rsp_ready=1; that edge returns to IDLE.
REQ-015 SHALL never accept a new request in the same cycle a response completes; steady-state throughput is one access per WAIT_CYCLES+2 cycles.
REQ-016 Addressing SHALL be little-endian: word index = addr[31:2], byte lane = addr[1:0].
REQ-017 A store SHALL write only the selected lanes (byte: lane addr[1:0]; half: lanes addr[1]*2..+1; word: all four); rsp_rdata for a store SHALL be 0.
REQ-018 A load SHALL return the selected byte/half right-aligned, sign-extended unless req_unsigned=1; word loads are unmodified.
REQ-019 SHALL flag an error when req_size=11 or word index >= DEPTH_WORDS; an errored access SHALL not modify the array, and SHALL return rsp_rdata=0 with rsp_error=1.
REQ-020 Non-error responses SHALL have rsp_error=0.

Reset
REQ-021 While reset=0, SHALL force: state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_error 0, and all array words 0.
REQ-022 req_ready SHALL be 1 from the first edge after reset release.
REQ-023 Reset asserted in BUSY or RESP SHALL abandon the transaction: an uncommitted store is not written, and no response is produced.

Configuration
REQ-024 Macro DATA_MEM_ALIGN_CHECK_EN defined: SHALL treat a half access with addr[0]=1, or a word access with addr[1:0]!=00, as an error per REQ-019.
REQ-025 Macro DATA_MEM_ALIGN_CHECK_EN undefined: SHALL ignore addr[0] for halves and addr[1:0] for words (forced aligned), with no misalignment error; REQ-019 checks still apply.

Verification (DEPTH_WORDS=256, WAIT_CYCLES=2 unless stated)
REQ-026 Store word 0xDEADBEEF @0x10, then load word @0x10 -> rsp_rdata=0xDEADBEEF, rsp_error=0, rsp_valid rising 3 edges after accept.
REQ-027 With that data: load byte @0x13 signed -> 0xFFFFFFDE; unsigned -> 0x000000DE; load half @0x12 signed -> 0xFFFFDEAD; store byte 0x55 @0x11 then load word @0x10 -> 0xDEAD55EF.
REQ-028 Hold rsp_ready=0 for 5 cycles in RESP while driving req_valid=1 -> rsp_valid/rsp_rdata/rsp_error constant, req_ready=0, and the new request is accepted only after the response handshake.
REQ-029 Load word @0x400 -> rsp_error=1, rsp_rdata=0; req_size=11 -> rsp_error=1. With DATA_MEM_ALIGN_CHECK_EN, load word @0x12 -> rsp_error=1; without it -> rsp_rdata=word @0x10.
REQ-030 Assert reset=0 while in BUSY of store 0x12345678 @0x20 -> rsp_valid=0 immediately; after release, load @0x20 returns 0x00000000.
REQ-031 WAIT_CYCLES=0: store then load @0x04 back-to-back -> each rsp_valid rises on the accept edge; load returns the stored value.

Source files
------------

// File: rtl/data_mem_responder.sv
// Single-port word memory answering one load/store at a time after a fixed wait.
// Define DATA_MEM_ALIGN_CHECK_EN to flag misaligned half/word accesses as errors.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_error_q, rsp_error_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic        do_access;
  logic        acc_wr, acc_uns, acc_err;
  logic [31:0] acc_addr, acc_wdata, acc_old, acc_shift, acc_load, acc_rdata;
  logic [31:0] acc_mask, acc_wshift, mem_wword;
  logic [1:0]  acc_size, acc_lane;
  logic [29:0] acc_widx;
  logic        mem_we;

  // With zero wait the access happens on the accept edge, so it must see the live request.
  always_comb begin
    if (state_q == IDLE) begin
      acc_wr    = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_size  = req_size;
      acc_uns   = req_unsigned;
    end else begin
      acc_wr    = wr_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_size  = size_q;
      acc_uns   = uns_q;
    end
  end

  always_comb begin
    acc_widx = acc_addr[31:2];
    acc_lane = acc_addr[1:0];
    acc_err  = (acc_size == 2'b11) || ({2'b00, acc_widx} >= DEPTH_WORDS);
`ifdef DATA_MEM_ALIGN_CHECK_EN
    if ((acc_size == 2'b01 && acc_lane[0]) || (acc_size == 2'b10 && acc_lane != 2'b00))
      acc_err = 1'b1;
`else
    if (acc_size == 2'b01)
      acc_lane[0] = 1'b0;
    else if (acc_size == 2'b10)
      acc_lane = 2'b00;
`endif
    acc_old   = acc_err ? '0 : mem_q[acc_widx[AW-1:0]];
    acc_shift = acc_old >> {acc_lane, 3'b000};

    case (acc_size)
      2'b00:   acc_load = acc_uns ? {24'd0, acc_shift[7:0]}
                                  : {{24{acc_shift[7]}}, acc_shift[7:0]};
      2'b01:   acc_load = acc_uns ? {16'd0, acc_shift[15:0]}
                                  : {{16{acc_shift[15]}}, acc_shift[15:0]};
      default: acc_load = acc_old;
    endcase

    case (acc_size)
      2'b00:   acc_mask = 32'h0000_00FF << {acc_lane, 3'b000};
      2'b01:   acc_mask = 32'h0000_FFFF << {acc_lane, 3'b000};
      default: acc_mask = '1;
    endcase
    acc_wshift = acc_wdata << {acc_lane, 3'b000};
    mem_wword  = (acc_old & ~acc_mask) | (acc_wshift & acc_mask);
    acc_rdata  = (acc_err || acc_wr) ? '0 : acc_load;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    uns_d       = uns_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    do_access   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_size;
          uns_d   = req_unsigned;
          if (WAIT_CYCLES == 0) begin
            do_access = 1'b1;
            state_d   = RESP;
          end else begin
            cnt_d   = WAIT_LOAD;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          do_access = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (do_access) begin
      rsp_rdata_d = acc_rdata;
      rsp_error_d = acc_err;
    end
  end

  assign mem_we = do_access && acc_wr && !acc_err;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++)
        mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[acc_widx[AW-1:0]] <= mem_wword;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: WAIT_CYCLES=2 and WAIT_CYCLES=0 instances against a byte-array model.
module tb_data_mem_responder;
  localparam int unsigned DEPTH = 256;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        req_valid, req_ready, req_write, req_unsigned, rsp_valid, rsp_ready, rsp_error;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [1:0]  req_size;
  logic        req_valid_z, req_ready_z, req_write_z, req_unsigned_z, rsp_valid_z, rsp_ready_z, rsp_error_z;
  logic [31:0] req_addr_z, req_wdata_z, rsp_rdata_z;
  logic [1:0]  req_size_z;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u_dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut_z (
    .clock(clock), .reset(reset),
    .req_valid(req_valid_z), .req_ready(req_ready_z), .req_write(req_write_z),
    .req_addr(req_addr_z), .req_wdata(req_wdata_z), .req_size(req_size_z),
    .req_unsigned(req_unsigned_z), .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z),
    .rsp_rdata(rsp_rdata_z), .rsp_error(rsp_error_z)
  );

  int n_checks = 0;
  int n_fail   = 0;
  byte unsigned ref_mem [2][DEPTH*4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Byte-addressed reference: a size-n access touches n consecutive bytes.
  function automatic void ref_access(input int which, input bit wr, input logic [31:0] addr,
                                     input logic [31:0] wdata, input logic [1:0] size, input bit uns,
                                     output logic [31:0] rdata, output bit err);
    int unsigned n = 1 << size;
    logic [31:0] a = addr;
    logic [31:0] v = '0;
    rdata = '0;
    err   = 1'b0;
    if (size == 2'b11) err = 1'b1;
`ifdef DATA_MEM_ALIGN_CHECK_EN
    else if (addr % n != 0) err = 1'b1;
`else
    else a = addr - (addr % n);
`endif
    if (addr / 4 >= DEPTH) err = 1'b1;
    if (err) return;
    for (int unsigned i = 0; i < n; i++) begin
      if (wr) ref_mem[which][a + i] = wdata[8*i +: 8];
      else    v = v | (32'(ref_mem[which][a + i]) << (8*i));
    end
    if (!wr) begin
      if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      rdata = v;
    end
  endfunction

  task automatic clear_ref();
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < DEPTH*4; i++)
        ref_mem[w][i] = 8'h00;
  endtask

  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input bit uns, input int hold, input bit hold_req,
                        input bit use_want, input logic [31:0] want, input string tag);
    logic [31:0] exp_d;
    bit          exp_e;
    int          edges;
    @(negedge clock);
    req_write = wr; req_addr = addr; req_wdata = wdata; req_size = size;
    req_unsigned = uns; req_valid = 1'b1;
    check({tag, ":req_ready"}, 32'(req_ready), 32'd1);
    ref_access(0, wr, addr, wdata, size, uns, exp_d, exp_e);
    @(posedge clock);
    edges = 1;
    @(negedge clock);
    req_valid = 1'b0;
    while (!rsp_valid && edges < 40) begin
      @(posedge clock);
      edges++;
      @(negedge clock);
    end
    check({tag, ":latency"}, 32'(edges), 32'd3);
    check({tag, ":rdata"}, rsp_rdata, exp_d);
    check({tag, ":error"}, 32'(rsp_error), 32'(exp_e));
    if (use_want) check({tag, ":want"}, rsp_rdata, want);
    for (int i = 0; i < hold; i++) begin
      if (hold_req) begin
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_size = 2'b10;
      end
      @(posedge clock);
      @(negedge clock);
      check({tag, ":hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, ":hold_rdata"}, rsp_rdata, exp_d);
      check({tag, ":hold_error"}, 32'(rsp_error), 32'(exp_e));
      check({tag, ":hold_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rsp_ready = 1'b0;
    check({tag, ":done_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, ":done_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic do_txn0(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input bit uns,
                         input bit use_want, input logic [31:0] want, input string tag);
    logic [31:0] exp_d;
    bit          exp_e;
    @(negedge clock);
    req_write_z = wr; req_addr_z = addr; req_wdata_z = wdata; req_size_z = size;
    req_unsigned_z = uns; req_valid_z = 1'b1;
    check({tag, ":req_ready"}, 32'(req_ready_z), 32'd1);
    ref_access(1, wr, addr, wdata, size, uns, exp_d, exp_e);
    @(posedge clock);
    @(negedge clock);
    req_valid_z = 1'b0;
    check({tag, ":latency"}, 32'(rsp_valid_z), 32'd1);
    check({tag, ":rdata"}, rsp_rdata_z, exp_d);
    check({tag, ":error"}, 32'(rsp_error_z), 32'(exp_e));
    if (use_want) check({tag, ":want"}, rsp_rdata_z, want);
    rsp_ready_z = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rsp_ready_z = 1'b0;
    check({tag, ":done_valid"}, 32'(rsp_valid_z), 32'd0);
  endtask

  task automatic rand_fields(output bit wr, output logic [31:0] addr, output logic [31:0] wdata,
                             output logic [1:0] size, output bit uns);
    wr    = 1'($urandom_range(0, 1));
    wdata = $urandom;
    uns   = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 9))
      0:       addr = $urandom;
      1:       addr = 32'h3F8 + 32'($urandom_range(0, 15));
      default: addr = 32'($urandom_range(0, 63));
    endcase
    size = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit          wr, uns;
    logic [31:0] addr, wdata, want_mis;
    logic [1:0]  size;

    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_size = '0;
    req_unsigned = 0; rsp_ready = 0;
    req_valid_z = 0; req_write_z = 0; req_addr_z = '0; req_wdata_z = '0; req_size_z = '0;
    req_unsigned_z = 0; rsp_ready_z = 0;
    clear_ref();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst:rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst:rsp_rdata", rsp_rdata, 32'd0);
    check("rst:rsp_error", 32'(rsp_error), 32'd0);
    check("rst:rsp_valid_z", 32'(rsp_valid_z), 32'd0);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("rst:req_ready", 32'(req_ready), 32'd1);

    do_txn(1, 32'h10, 32'hDEADBEEF, 2'b10, 0, 0, 0, 1, 32'h0, "st_w");
    do_txn(0, 32'h10, 32'h0, 2'b10, 0, 0, 0, 1, 32'hDEADBEEF, "ld_w");
    do_txn(0, 32'h13, 32'h0, 2'b00, 0, 0, 0, 1, 32'hFFFFFFDE, "ld_b_s");
    do_txn(0, 32'h13, 32'h0, 2'b00, 1, 0, 0, 1, 32'h000000DE, "ld_b_u");
    do_txn(0, 32'h12, 32'h0, 2'b01, 0, 0, 0, 1, 32'hFFFFDEAD, "ld_h_s");
    do_txn(1, 32'h11, 32'h55, 2'b00, 0, 0, 0, 1, 32'h0, "st_b");
    do_txn(0, 32'h10, 32'h0, 2'b10, 0, 5, 1, 1, 32'hDEAD55EF, "ld_hold");
    do_txn(0, 32'h10, 32'h0, 2'b10, 0, 0, 0, 1, 32'hDEAD55EF, "ld_after_hold");
    do_txn(0, 32'h400, 32'h0, 2'b10, 0, 0, 0, 1, 32'h0, "oob");
    do_txn(0, 32'h10, 32'h0, 2'b11, 0, 0, 0, 1, 32'h0, "size3");
`ifdef DATA_MEM_ALIGN_CHECK_EN
    want_mis = 32'h0;
`else
    want_mis = 32'hDEAD55EF;
`endif
    do_txn(0, 32'h12, 32'h0, 2'b10, 0, 0, 0, 1, want_mis, "misalign");

    for (int i = 0; i < 150; i++) begin
      rand_fields(wr, addr, wdata, size, uns);
      do_txn(wr, addr, wdata, size, uns, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0, '0, "rnd");
    end

    do_txn0(1, 32'h04, 32'hCAFEF00D, 2'b10, 0, 1, 32'h0, "z_st");
    do_txn0(0, 32'h04, 32'h0, 2'b10, 0, 1, 32'hCAFEF00D, "z_ld");
    for (int i = 0; i < 40; i++) begin
      rand_fields(wr, addr, wdata, size, uns);
      do_txn0(wr, addr, wdata, size, uns, 0, '0, "z_rnd");
    end

    // Reset while the store is still waiting: nothing must be committed.
    @(negedge clock);
    req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_size = 2'b10;
    req_unsigned = 1'b0; req_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    check("busy:req_ready", 32'(req_ready), 32'd0);
    check("busy:rsp_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    #1;
    check("abort:rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort:rsp_rdata", rsp_rdata, 32'd0);
    clear_ref();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("abort:req_ready", 32'(req_ready), 32'd1);
    check("abort:rsp_valid2", 32'(rsp_valid), 32'd0);
    do_txn(0, 32'h20, 32'h0, 2'b10, 0, 0, 0, 1, 32'h0, "ld_after_rst");
    do_txn(0, 32'h10, 32'h0, 2'b10, 0, 0, 0, 1, 32'h0, "ld_cleared");
    do_txn0(0, 32'h04, 32'h0, 2'b10, 0, 1, 32'h0, "z_cleared");
    for (int i = 0; i < 30; i++) begin
      rand_fields(wr, addr, wdata, size, uns);
      do_txn(wr, addr, wdata, size, uns, $urandom_range(0, 2), 0, 0, '0, "rnd2");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
